// File: rtl/window_5x5_gen.sv
// Raster-to-neighbourhood converter: four cascaded line buffers feed a 5x5
// register window, emitting one full window per accepted pixel in the valid region.
module window_5x5_gen #(
  parameter int DSIZE = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_vld,
  input  logic                  in_sof,
  input  logic [DSIZE-1:0]      in_data,
  output logic                  out_vld,
  output logic                  out_sof,
  output logic [25*DSIZE-1:0]   out_win
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic             accept;
  logic [CW-1:0]    col, col_cur, col_nxt;
  logic [RW-1:0]    row, row_cur, row_nxt;
  logic             win_ok, win_first;

  // One RAM word per column holds all four lines: lane 0 is the previous line,
  // lane 3 the line four rows back.
  logic [4*DSIZE-1:0] lb_mem [IMG_W];
  logic [4*DSIZE-1:0] lb_rd;

  logic [DSIZE-1:0]   win     [5][5];
  logic [DSIZE-1:0]   win_nxt [5][5];
  logic [25*DSIZE-1:0] win_flat;

  assign accept = in_vld && !reset;

  // NOTE: every signal driven here is assigned a default up front so no path
  // leaves it unassigned, which is what keeps a combinational block latch-free.
  always_comb begin
    col_cur   = in_sof ? '0 : col;
    row_cur   = in_sof ? '0 : row;
    col_nxt   = col;
    row_nxt   = row;
    win_ok    = (row_cur >= RW'(4)) && (col_cur >= CW'(4));
    win_first = (row_cur == RW'(4)) && (col_cur == CW'(4));
    if (accept) begin
      if (col_cur == COL_LAST) begin
        col_nxt = '0;
        row_nxt = (row_cur == ROW_LAST) ? '0 : row_cur + RW'(1);
      end else begin
        col_nxt = col_cur + CW'(1);
        row_nxt = row_cur;
      end
    end
    if (reset) begin
      col_nxt = '0;
      row_nxt = '0;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

  // The read port prefetches the column of the next pixel, so the registered
  // read is ready when that pixel arrives and output latency stays one cycle.
  // NOTE: the line RAM and window array carry no reset; stale contents are
  // never observed because windows are only emitted from row 4, col 4 onward.
  always_ff @(posedge clock) begin
    if (accept) begin
      lb_mem[col_cur] <= {lb_rd[3*DSIZE-1:0], in_data};
    end
    lb_rd <= lb_mem[col_nxt];
  end

  always_comb begin
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        win_nxt[r][c] = win[r][c+1];
      end
    end
    for (int r = 0; r < 4; r++) begin
      win_nxt[r][4] = lb_rd[(3-r)*DSIZE +: DSIZE];
    end
    win_nxt[4][4] = in_data;
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        win_flat[(5*r+c)*DSIZE +: DSIZE] = win_nxt[r][c];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      win <= win_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_vld <= 1'b0;
      out_sof <= 1'b0;
      out_win <= '0;
    end else begin
      out_vld <= accept && win_ok;
      out_sof <= accept && win_first;
      if (accept && win_ok) begin
        out_win <= win_flat;
      end
    end
  end

endmodule
